// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   XLEN        - architectural word width
//   INSTR_BYTES - PC increment per fetched instruction
//   fetch_pkt_t - {instr, pc} entry held in the instruction buffer
//   cnt_w()     - width of a counter that must hold 0..depth inclusive
package fetch_unit_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Small synchronous FIFO (register storage) used by the fetch stage.
//   clk, rst          - clock, asynchronous active-high reset
//   push, push_data   - write an entry (accepted when not full, or full with a pop)
//   pop               - retire the head entry (ignored when empty)
//   flush             - drop all entries; wins over push/pop in the same cycle
//   pop_data          - head entry (stale contents when empty)
//   full, empty, count
module fetch_unit_sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the decoder.
//   clk, rst                          - clock, asynchronous active-high reset
//   imem_req_valid/ready/addr         - word fetch request to instruction memory (addr = PC)
//   imem_resp_valid/data              - in-order fetch responses
//   redirect_valid/pc                 - PC redirect from execute; flushes the stage
//   instr_valid/ready, instr/instr_pc - fetched instruction and its PC to decode
// Requests are credit limited: in-flight plus buffered never exceeds FIFO_DEPTH, so
// the instruction buffer cannot overflow. Requests in flight at a redirect are
// counted in drop_cnt and their responses discarded on return.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int CW = cnt_w(FIFO_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    fetch_pkt_t      buf_in, buf_out;
    logic [CW-1:0]   buf_count;
    logic            buf_empty, buf_full, buf_push;
    logic [XLEN-1:0] pcq_head;
    logic [CW-1:0]   pcq_count;
    logic            pcq_empty, pcq_full;

    logic [CW:0]     inflight_sum;
    logic            credit_ok, req_fire, resp_ok, deq;

    assign inflight_sum = {1'b0, outstanding_q} + {1'b0, buf_count};
    assign credit_ok    = (inflight_sum < (CW+1)'(FIFO_DEPTH));

    // Gated by rst so the request is low while reset is held.
    assign imem_req_valid = credit_ok & ~rst;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_ok = imem_resp_valid & (outstanding_q != '0);

    assign instr_valid = ~buf_empty & ~redirect_valid;
    assign deq         = instr_valid & instr_ready;
    assign instr       = buf_out.instr;
    assign instr_pc    = buf_out.pc;

    assign buf_push = resp_ok & (drop_cnt_q == '0) & ~redirect_valid;
    assign buf_in   = '{instr: imem_resp_data, pc: pcq_head};

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (req_fire) begin
            pc_d = pc_q + XLEN'(INSTR_BYTES);
        end

        outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_ok);

        // On redirect every request still out after this cycle (including one
        // firing now with the old PC) returns stale data.
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            drop_cnt_d = outstanding_d;
        end else if (resp_ok && drop_cnt_q != '0) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_unit_sync_fifo #(.WIDTH($bits(fetch_pkt_t)), .DEPTH(FIFO_DEPTH)) u_instr_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (deq),
        .flush     (redirect_valid),
        .pop_data  (buf_out),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    // PCs of requests in flight; never flushed, since dropped responses still
    // return and must retire their entry.
    fetch_unit_sync_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (resp_ok),
        .flush     (1'b0),
        .pop_data  (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_count)
    );

    logic unused_ok;
    assign unused_ok = &{1'b0, buf_full, pcq_full, pcq_empty, pcq_count};

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          D   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_fire;
    logic [31:0] memq[$];       // addresses accepted by memory, oldest first
    logic [31:0] exp_pc;        // next PC decode must see (program order)
    logic [31:0] req_pc;        // next address fetch must request
    bit          prev_req_wait, prev_hold;
    logic [31:0] prev_addr, prev_ipc, prev_instr;

    // Memory image: a fixed scramble of the address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        instr_ready     = 1'b0;
    endtask

    task automatic model_reset();
        memq.delete();
        exp_pc        = RPC;
        req_pc        = RPC;
        n_fire        = 0;
        prev_req_wait = 1'b0;
        prev_hold     = 1'b0;
    endtask

    // Asserts reset for one cycle, checks the immediate reset state, releases.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    // One clock: ready/resp/decode-ready with the given percent probabilities.
    task automatic cycle(input int pr, input int ps, input int pi,
                         input bit redir, input logic [31:0] rpc, input bit spur);
        bit          pop_now, fire, deq;
        logic [31:0] fire_addr;
        imem_req_ready = (int'($urandom_range(99)) < pr);
        pop_now = 1'b0;
        if (memq.size() > 0 && int'($urandom_range(99)) < ps) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word_at(memq[0]);
            pop_now         = 1'b1;
        end else begin
            imem_resp_valid = spur && (memq.size() == 0);
            imem_resp_data  = $urandom;
        end
        instr_ready    = (int'($urandom_range(99)) < pi);
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        if (prev_req_wait) begin
            chk("req_hold_valid", imem_req_valid, 1);
            chk("req_hold_addr", imem_req_addr, prev_addr);
        end
        if (prev_hold && !redir) begin
            chk("out_hold_valid", instr_valid, 1);
            chk("out_hold_pc", instr_pc, prev_ipc);
            chk("out_hold_instr", instr, prev_instr);
        end
        if (redir) chk("redir_no_instr", instr_valid, 0);
        fire = imem_req_valid & imem_req_ready;
        deq  = instr_valid & instr_ready;
        fire_addr = req_pc;
        if (fire) begin
            chk("req_addr", imem_req_addr, req_pc);
            req_pc += 32'd4;
            n_fire++;
        end
        if (deq) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr", instr, word_at(exp_pc));
            exp_pc += 32'd4;
        end
        if (redir) begin
            req_pc = {rpc[31:2], 2'b00};
            exp_pc = req_pc;
        end
        if (pop_now) void'(memq.pop_front());
        if (fire) memq.push_back(fire_addr);
        chk("inflight_le_depth", 32'(memq.size() <= D), 1);
        prev_req_wait = imem_req_valid & ~imem_req_ready & ~redir;
        prev_addr     = imem_req_addr;
        prev_hold     = instr_valid & ~instr_ready;
        prev_ipc      = instr_pc;
        prev_instr    = instr;
        @(posedge clk); #1;
        idle_inputs();
        #1;
    endtask

    initial begin
        int          pr, ps, pi;
        logic [31:0] tgt;
        rst = 1'b1;
        idle_inputs();
        model_reset();

        // 1: streaming fetch, registered response-to-output latency
        do_reset();
        chk("t1_first_req_valid", imem_req_valid, 1);
        chk("t1_first_req_addr", imem_req_addr, RPC);
        cycle(100, 100, 100, 0, 0, 0);
        chk("t1_addr_after_fire", imem_req_addr, RPC + 32'd4);
        chk("t1_no_instr_yet", instr_valid, 0);
        cycle(100, 100, 100, 0, 0, 0);
        chk("t1_instr_valid", instr_valid, 1);
        chk("t1_instr_pc", instr_pc, RPC);
        chk("t1_instr", instr, word_at(RPC));
        repeat (10) cycle(100, 100, 100, 0, 0, 0);

        // 2: decode stalled -> only FIFO_DEPTH requests, then stall
        do_reset();
        repeat (10) cycle(100, 100, 0, 0, 0, 0);
        chk("t2_fire_count", n_fire, D);
        chk("t2_req_blocked", imem_req_valid, 0);
        chk("t2_head_pc", instr_pc, RPC);

        // 3: redirect with two in flight, misaligned target
        do_reset();
        repeat (2) cycle(100, 0, 0, 0, 0, 0);
        chk("t3_credit_full", imem_req_valid, 0);
        cycle(0, 0, 0, 1, 32'h0000_1003, 0);
        chk("t3_redirect_addr", imem_req_addr, 32'h0000_1000);
        chk("t3_still_blocked", imem_req_valid, 0);
        cycle(0, 100, 100, 0, 0, 0);
        chk("t3_drop1", instr_valid, 0);
        cycle(0, 100, 100, 0, 0, 0);
        chk("t3_drop2", instr_valid, 0);
        chk("t3_refetch_valid", imem_req_valid, 1);
        cycle(100, 0, 100, 0, 0, 0);
        cycle(0, 100, 100, 0, 0, 0);
        chk("t3_new_valid", instr_valid, 1);
        chk("t3_new_pc", instr_pc, 32'h0000_1000);
        repeat (4) cycle(100, 100, 100, 0, 0, 0);

        // 4: redirect coinciding with a response and a request fire
        do_reset();
        cycle(100, 0, 100, 0, 0, 0);
        cycle(100, 100, 100, 1, 32'h0000_2000, 0);
        chk("t4_addr", imem_req_addr, 32'h0000_2000);
        chk("t4_no_instr", instr_valid, 0);
        chk("t4_credit", imem_req_valid, 1);
        cycle(0, 100, 100, 0, 0, 0);
        chk("t4_fired_dropped", instr_valid, 0);
        cycle(100, 0, 100, 0, 0, 0);
        cycle(0, 100, 100, 0, 0, 0);
        chk("t4_new_valid", instr_valid, 1);
        chk("t4_new_pc", instr_pc, 32'h0000_2000);
        chk("t4_new_instr", instr, word_at(32'h0000_2000));

        // 5: PC wrap at top of address space
        do_reset();
        cycle(0, 0, 0, 1, 32'hFFFF_FFFF, 0);
        chk("t5_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        cycle(100, 0, 0, 0, 0, 0);
        chk("t5_wrap_addr", imem_req_addr, 32'h0000_0000);
        cycle(0, 100, 100, 0, 0, 0);
        chk("t5_top_pc", instr_pc, 32'hFFFF_FFFC);
        repeat (4) cycle(100, 100, 100, 0, 0, 0);

        // spurious response with nothing outstanding must not disturb credit
        do_reset();
        cycle(0, 0, 0, 0, 0, 1);
        chk("spur_req_valid", imem_req_valid, 1);
        chk("spur_no_instr", instr_valid, 0);
        repeat (6) cycle(100, 100, 100, 0, 0, 0);
        chk("spur_fires", 32'(n_fire >= 2), 1);

        // 6: reset mid-stream
        do_reset();
        repeat (2) cycle(100, 0, 0, 0, 0, 0);
        cycle(0, 100, 0, 0, 0, 0);
        chk("t6_pre_valid", instr_valid, 1);
        chk("t6_pre_addr", imem_req_addr, RPC + 32'd8);
        do_reset();
        chk("t6_resume_addr", imem_req_addr, RPC);
        chk("t6_resume_valid", imem_req_valid, 1);
        repeat (6) cycle(100, 100, 100, 0, 0, 0);

        // random traffic against the program-order model
        do_reset();
        pr = 100; ps = 100; pi = 100;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                pr = int'($urandom_range(100, 20));
                ps = int'($urandom_range(100, 20));
                pi = int'($urandom_range(100, 10));
            end
            if ($urandom_range(99) < 4) begin
                case ($urandom_range(2))
                    0:       tgt = $urandom;
                    1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(15));
                    default: tgt = 32'($urandom_range(63));
                endcase
                cycle(pr, ps, pi, 1, tgt, 0);
            end else begin
                cycle(pr, ps, pi, 0, 0, $urandom_range(9) == 0);
            end
        end
        repeat (12) cycle(0, 100, 100, 0, 0, 0);
        chk("drain_memq_empty", memq.size(), 0);
        chk("drain_no_instr", instr_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
